master_cnn_conv_acc: RTL and testbench
======================================

// Module: master_cnn_conv_acc
// PURPOSE
//  Accumulate stage directly downstream of the 17x18 conv tap multiplier: sums KERNEL_LEN signed products per output point.
//  Adds the per-channel bias, rounds, shifts and saturates the sum, then presents one OUT_WIDTH result per window.
//  Uses a valid/ready handshake on both sides and feeds the activation/store stage of the Conv1D pipeline.
// PARAMETERS
//  PROD_WIDTH  35  signed product width from multiplier (Q.FRAC_SHIFT)
//  ACC_WIDTH   40  accumulator width; must be >= PROD_WIDTH+clog2(KERNEL_LEN)+1
//  OUT_WIDTH   18  signed output width
//  KERNEL_LEN  12  products per output window (>=1)
//  FRAC_SHIFT  17  fractional bits removed at output (>=1)
// PORTS
//  ap_clk      in   1           clock, all logic on rising edge
//  ap_rst      in   1           synchronous active-high reset
//  bias        in   OUT_WIDTH   signed bias, sampled on first product of each window
//  prod_valid  in   1           prod_data valid
//  prod_ready  out  1           block accepts a product this cycle
//  prod_data   in   PROD_WIDTH  signed product
//  out_valid   out  1           out_data valid
//  out_ready   in   1           consumer accepts out_data
//  out_data    out  OUT_WIDTH   signed rounded/saturated result
//  out_sat     out  1           result was clipped (qualified by out_valid)
//  busy        out  1           window partially accumulated (tap_cnt != 0)
// BEHAVIOUR
//  Reset: state=ACC, tap_cnt=0, acc=0, out_valid=0, out_data=0, out_sat=0; prod_ready=1 on the first cycle after reset.
//  Transfer happens when valid&&ready are both high on the same edge; the other side never waits combinationally on it.
//  FSM: ACC (prod_ready=1, out_valid=0) / OUT (prod_ready=0, out_valid=1).
//  ACC, product accepted, tap_cnt==0: acc <= sext(bias)<<FRAC_SHIFT + 2^(FRAC_SHIFT-1) + sext(prod_data).
//  ACC, product accepted, tap_cnt!=0: acc <= acc + sext(prod_data).
//  tap_cnt increments per accepted product. The product with tap_cnt==KERNEL_LEN-1 closes the window:
//   result computed from the updated sum, registered into out_data/out_sat, tap_cnt<=0, state<=OUT.
//  Latency: out_valid rises 1 cycle after the last product is accepted.
//  OUT: out_data/out_sat held stable while out_ready=0. On out_ready: state<=ACC, out_valid<=0.
//   The next product can be accepted the cycle after that; no overlap. Max throughput is KERNEL_LEN+1 cycles/result.
//  Result: r = sum >>> FRAC_SHIFT (arithmetic). This is round-half-up via the preloaded 2^(FRAC_SHIFT-1).
//   r > 2^(OUT_WIDTH-1)-1 -> out_data = max, out_sat=1.
//   r < -2^(OUT_WIDTH-1) -> out_data = min, out_sat=1.
//   Otherwise out_data = r[OUT_WIDTH-1:0], out_sat=0.
//  No intermediate wrap is possible given the ACC_WIDTH rule. Saturation is applied only at the output.
//  KERNEL_LEN==1: every accepted product closes a window.
//  prod_valid in OUT is ignored, and prod_data is not sampled.
//  Reset mid-window or in OUT: partial sum and pending result are discarded, and the block returns to reset values.
//  bias changes mid-window have no effect until the next window's first product.
// CONFIGURATION
//  CONV_ACC_RELU_EN defined: ReLU is applied after saturation. Negative r gives out_data=0; out_sat reflects positive clipping only.
//   Negative r therefore never asserts out_sat.
//  CONV_ACC_RELU_EN undefined: signed output with symmetric saturation as above, and no ReLU logic is present.
// TESTING (defaults KERNEL_LEN=12, FRAC_SHIFT=17, OUT_WIDTH=18)
//  1 bias=0, 12 products of 0x20000 (1.0), out_ready=1 -> out_data=12, out_sat=0; out_valid 1 cycle after 12th accept.
//  2 bias=5, same products -> out_data=17. Change bias to -3 after tap 4 -> still 17; the next window uses -3.
//  3 Rounding: bias=0, products sum to +0x10000 -> 1; sum to -0x10000 -> 0; sum to -0x10001 -> -1.
//  4 Saturation: 12 products of 2^34-1 -> out_data=131071, out_sat=1.
//     12 products of -2^34 -> -131072, out_sat=1 (RELU_EN: 0, out_sat=0).
//  5 Backpressure: out_ready=0 for 3 cycles in OUT -> out_data stable, prod_ready=0, prod_valid ignored.
//     out_ready=1 -> prod_ready=1 next cycle.
//  6 Reset: assert ap_rst after tap 7 -> busy=0. A fresh 12-product window of 0x20000 with bias=0 -> out_data=12, not 19.

Source files
------------

// File: rtl/master_cnn_conv_acc_if.sv
// Handshake/bus bundle between the conv tap multiplier, this accumulator and
// the activation/store stage. The slave modport is the accumulator's view.
`timescale 1ns/1ps
interface master_cnn_conv_acc_if #(
  parameter int unsigned PROD_WIDTH = 35,
  parameter int unsigned OUT_WIDTH  = 18
);
  logic signed [OUT_WIDTH-1:0]  bias;
  logic                         prod_valid;
  logic                         prod_ready;
  logic signed [PROD_WIDTH-1:0] prod_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_sat;
  logic                         busy;

  modport slave (
    input  bias, prod_valid, prod_data, out_ready,
    output prod_ready, out_valid, out_data, out_sat, busy
  );

  modport master (
    output bias, prod_valid, prod_data, out_ready,
    input  prod_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/master_cnn_conv_acc.sv
// Conv1D accumulate stage: sums KERNEL_LEN signed products per window,
// preloads bias and a half-LSB rounding constant on the first tap, then
// shifts, saturates and presents one OUT_WIDTH result per window.
// Optional feature macro: CONV_ACC_RELU_EN (ReLU after saturation).
`timescale 1ns/1ps
module master_cnn_conv_acc #(
  parameter int unsigned PROD_WIDTH = 35,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned OUT_WIDTH  = 18,
  parameter int unsigned KERNEL_LEN = 12,
  parameter int unsigned FRAC_SHIFT = 17
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  master_cnn_conv_acc_if.slave bus
);

  localparam int unsigned CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERNEL_LEN - 1);
  localparam logic signed [ACC_WIDTH-1:0] ROUND_K =
    ACC_WIDTH'(64'sd1 <<< (FRAC_SHIFT - 1));
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_e;

  state_e                        state_q;
  logic [CNT_W-1:0]              tap_cnt_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [ACC_WIDTH-1:0]   acc_d;
  logic signed [ACC_WIDTH-1:0]   acc_base;
  logic signed [ACC_WIDTH-1:0]   sum_shr;
  logic signed [OUT_WIDTH-1:0]   res_data;
  logic                          res_sat;
  logic                          prod_ready_q;
  logic                          out_valid_q;
  logic signed [OUT_WIDTH-1:0]   out_data_q;
  logic                          out_sat_q;
  logic                          busy_q;

  // Next accumulator value and the rounded/shifted/saturated window result.
  always_comb begin
    acc_base = acc_q;
    if (tap_cnt_q == '0) begin
      acc_base = (ACC_WIDTH'(bus.bias) <<< FRAC_SHIFT) + ROUND_K;
    end
    acc_d   = acc_base + ACC_WIDTH'(bus.prod_data);
    sum_shr = acc_d >>> FRAC_SHIFT;
`ifdef CONV_ACC_RELU_EN
    if (sum_shr < 0) begin
      res_data = '0;
      res_sat  = 1'b0;
    end else if (sum_shr > OUT_MAX) begin
      res_data = OUT_MAX[OUT_WIDTH-1:0];
      res_sat  = 1'b1;
    end else begin
      res_data = sum_shr[OUT_WIDTH-1:0];
      res_sat  = 1'b0;
    end
`else
    if (sum_shr > OUT_MAX) begin
      res_data = OUT_MAX[OUT_WIDTH-1:0];
      res_sat  = 1'b1;
    end else if (sum_shr < OUT_MIN) begin
      res_data = OUT_MIN[OUT_WIDTH-1:0];
      res_sat  = 1'b1;
    end else begin
      res_data = sum_shr[OUT_WIDTH-1:0];
      res_sat  = 1'b0;
    end
`endif
  end

  // ACC/OUT control FSM with registered handshake and result outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= ST_ACC;
      tap_cnt_q    <= '0;
      acc_q        <= '0;
      prod_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (bus.prod_valid) begin
            acc_q <= acc_d;
            if (tap_cnt_q == LAST_TAP) begin
              tap_cnt_q    <= '0;
              busy_q       <= 1'b0;
              out_data_q   <= res_data;
              out_sat_q    <= res_sat;
              out_valid_q  <= 1'b1;
              prod_ready_q <= 1'b0;
              state_q      <= ST_OUT;
            end else begin
              tap_cnt_q <= tap_cnt_q + CNT_W'(1);
              busy_q    <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
            prod_ready_q <= 1'b1;
            state_q      <= ST_ACC;
          end
        end
        default: begin
          state_q <= ST_ACC;
        end
      endcase
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_sat    = out_sat_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_master_cnn_conv_acc.sv
// Directed bench for master_cnn_conv_acc at default parameters.
`timescale 1ns/1ps
module tb_master_cnn_conv_acc;

  localparam int unsigned PW = 35;
  localparam int unsigned OW = 18;
  localparam int unsigned KL = 12;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  master_cnn_conv_acc_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) bus ();

  master_cnn_conv_acc dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and wait (bounded) until it is accepted.
  task automatic push(input logic signed [PW-1:0] d);
    logic rdy;
    logic done;
    done = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod_data  = d;
    for (int i = 0; i < 40; i++) begin
      rdy = bus.prod_ready;
      tick();
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    bus.prod_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  // Wait (bounded) for a result, check it, then consume it.
  task automatic take(input string tag, input longint exp_d, input longint exp_s);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_data"}, longint'(bus.out_data), exp_d);
      chk({tag, "_sat"}, longint'(bus.out_sat), exp_s);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic window(input logic signed [PW-1:0] d);
    for (int i = 0; i < int'(KL); i++) push(d);
  endtask

  initial begin
    logic signed [PW-1:0] one;
    logic signed [PW-1:0] pmax;
    logic signed [PW-1:0] pmin;
    logic signed [PW-1:0] junk;
    total = 0;
    bad   = 0;
    one   = PW'(35'sh20000);
    pmax  = PW'((64'sd1 <<< 34) - 64'sd1);
    pmin  = PW'(-(64'sd1 <<< 34));
    junk  = PW'(35'sh3_0000_1234);
    rst = 1'b1;
    bus.bias = '0;
    bus.prod_valid = 1'b0;
    bus.prod_data = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_out_sat", longint'(bus.out_sat), 0);
    chk("rst_prod_ready", longint'(bus.prod_ready), 1);
    chk("rst_busy", longint'(bus.busy), 0);

    // 1: unit products, latency check right after the closing accept
    bus.bias = 18'sd0;
    for (int i = 0; i < int'(KL) - 1; i++) push(one);
    chk("t1_busy", longint'(bus.busy), 1);
    chk("t1_valid_early", longint'(bus.out_valid), 0);
    push(one);
    chk("t1_latency", longint'(bus.out_valid), 1);
    chk("t1_busy_end", longint'(bus.busy), 0);
    take("t1", 12, 0);

    // 2: bias, and a mid-window bias change that must not apply
    bus.bias = 18'sd5;
    for (int i = 0; i < 4; i++) push(one);
    bus.bias = -18'sd3;
    for (int i = 4; i < int'(KL); i++) push(one);
    take("t2_bias5", 17, 0);
    window(one);
    take("t2_biasm3", 9, 0);

    // 3: rounding at the half-LSB boundary
    bus.bias = 18'sd0;
    push(PW'(35'sh10000));
    for (int i = 1; i < int'(KL); i++) push('0);
    take("t3_pos_half", 1, 0);
    push(-PW'(35'sh10000));
    for (int i = 1; i < int'(KL); i++) push('0);
    take("t3_neg_half", 0, 0);
    push(-PW'(35'sh10001));
    for (int i = 1; i < int'(KL); i++) push('0);
    take("t3_neg_over", -1, 0);

    // 4: saturation at both rails
    window(pmax);
    take("t4_pos_sat", 131071, 1);
    window(pmin);
`ifdef CONV_ACC_RELU_EN
    take("t4_neg_sat", 0, 0);
`else
    take("t4_neg_sat", -131072, 1);
`endif

    // 5: backpressure, products offered in OUT are ignored
    window(one);
    bus.prod_valid = 1'b1;
    bus.prod_data  = junk;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_data", longint'(bus.out_data), 12);
      chk("t5_hold_valid", longint'(bus.out_valid), 1);
      chk("t5_hold_pready", longint'(bus.prod_ready), 0);
    end
    bus.prod_valid = 1'b0;
    bus.out_ready  = 1'b1;
    tick();
    bus.out_ready  = 1'b0;
    chk("t5_release_valid", longint'(bus.out_valid), 0);
    chk("t5_release_pready", longint'(bus.prod_ready), 1);
    window(one);
    take("t5_after", 12, 0);

    // 6: reset mid-window discards the partial sum
    for (int i = 0; i < 7; i++) push(one);
    chk("t6_busy_pre", longint'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy_rst", longint'(bus.busy), 0);
    chk("t6_pready_rst", longint'(bus.prod_ready), 1);
    window(one);
    take("t6_fresh", 12, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
